// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the shared 256-bit line memory port: grants one
// cache, drives the memory until ack (or timeout), then returns a one-cycle ack.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 256,
  parameter int unsigned ARB_MODE = 0,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              p0_enable_i,
  input  logic              p0_write_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [DATA_W-1:0] p0_data_i,
  output logic              p0_ack_o,
  output logic [DATA_W-1:0] p0_data_o,
  input  logic              p1_enable_i,
  input  logic              p1_write_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  output logic              p1_ack_o,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic              grant_o,
  output logic              err_o
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_rr_ptr;

  logic               w_any_req;
  logic               w_sel;
  logic               w_sel_write;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_data;

  // Winner selection; r_rr_ptr names the port that wins a tie in round-robin mode
  always_comb begin
    w_any_req = p0_enable_i | p1_enable_i;
    w_sel     = p1_enable_i;
    if ((ARB_MODE != 0) && p0_enable_i && p1_enable_i) begin
      w_sel = r_rr_ptr;
    end
    w_sel_write = w_sel ? p1_write_i : p0_write_i;
    w_sel_addr  = w_sel ? p1_addr_i  : p0_addr_i;
    w_sel_data  = w_sel ? p1_data_i  : p0_data_i;
  end

  // Memory-side outputs double as the latched request and are zeroed outside BUSY
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_rr_ptr     <= 1'b0;
      p0_ack_o     <= 1'b0;
      p1_ack_o     <= 1'b0;
      p0_data_o    <= '0;
      p1_data_o    <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
      grant_o      <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      p0_ack_o <= 1'b0;
      p1_ack_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_state      <= ST_BUSY;
            r_cnt        <= '0;
            r_rr_ptr     <= ~w_sel;
            grant_o      <= w_sel;
            mem_enable_o <= 1'b1;
            mem_write_o  <= w_sel_write;
            mem_addr_o   <= w_sel_addr;
            mem_data_o   <= w_sel_data;
          end
        end
        ST_BUSY: begin
          // An ack on the limit cycle still counts as a normal completion
          if (mem_ack_i || (r_cnt == CNT_LAST)) begin
            r_state      <= ST_RESP;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            if (grant_o) begin
              p1_ack_o <= 1'b1;
            end else begin
              p0_ack_o <= 1'b1;
            end
            if (mem_ack_i && !mem_write_o) begin
              if (grant_o) begin
                p1_data_o <= mem_data_i;
              end else begin
                p0_data_o <= mem_data_i;
              end
            end
            if (!mem_ack_i) begin
              err_o <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single 256-bit off-chip data memory port between two cache-line requesters: port 0 is the instruction cache and port 1 is the data cache.
It sits between the caches and the data memory model, which hold one request at a time and end it with a one-cycle ack.
It grants one requester, latches that request, and drives the memory port until ack. It then returns a registered response and guards against a memory that never acks.

Parameters:
ADDR_W, 32, address width
DATA_W, 256, line width
ARB_MODE, 0, 0 = fixed priority (port 1 wins), 1 = round-robin
TIMEOUT, 64, max cycles in BUSY before error (>=2)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
p0_enable_i  in  1  port 0 request, held until p0_ack_o
p0_write_i  in  1  port 0: 1 = line write
p0_addr_i  in  ADDR_W  port 0 line address
p0_data_i  in  DATA_W  port 0 write line
p0_ack_o  out  1  port 0 done, one-cycle pulse
p0_data_o  out  DATA_W  port 0 read line
p1_enable_i, p1_write_i, p1_addr_i, p1_data_i, p1_ack_o, p1_data_o  same as port 0, for port 1
mem_enable_o  out  1  memory request
mem_write_o  out  1  memory write
mem_addr_o  out  ADDR_W  memory address
mem_data_o  out  DATA_W  memory write line
mem_data_i  in  DATA_W  memory read line
mem_ack_i  in  1  memory done, one-cycle pulse
grant_o  out  1  owner of current/last transaction (0/1)
err_o  out  1  sticky timeout flag

Behaviour:
- Reset (rst_i=0, any time, including mid-transaction): state=IDLE; all outputs 0; rr pointer=0; timeout counter=0; latched request cleared. The in-flight request is abandoned.
- States:
  - IDLE: if any pN_enable_i, choose winner, latch its write/addr/data and grant_o, go BUSY next edge. Otherwise stay.
  - BUSY: mem_enable_o=1; mem_write/addr/data_o come from the latch and are stable all of BUSY. On mem_ack_i: if read, register mem_data_i into winner's pN_data_o; go RESP.
  - RESP: mem_enable_o=0; winner's pN_ack_o=1 for exactly this cycle; go IDLE.
- Selection, fixed mode: port 1 if p1_enable_i, else port 0.
- Selection, round-robin mode: when both request, grant the port not granted last. The pointer updates on each grant.
- Latency: request seen in IDLE at cycle T gives mem_enable_o at T+1. mem_ack_i at cycle A gives pN_ack_o at A+1. Minimum turnaround is 3 cycles; back-to-back grants need one IDLE cycle.
- pN_data_o holds its last read line until the next read for that port; writes do not change it. The losing port's outputs never change.
- Requester inputs that change during BUSY/RESP are ignored (latched copy is used). A requester that drops enable before ack still receives the ack.
- mem_ack_i in IDLE or RESP is ignored.
- Timeout: counter clears on entering BUSY and increments each BUSY cycle.
  - At TIMEOUT cycles without mem_ack_i: set err_o, force RESP with pN_ack_o=1, pN_data_o unchanged.
  - err_o clears only on reset.
- A simultaneous mem_ack_i and timeout limit count as a normal ack; err_o is not set.
- mem_write_o and mem_addr_o are 0 outside BUSY.

Test Plan:
1. Port 0 read only, addr 0x0000_0400, memory acks 5 cycles after enable -> mem_enable_o high 5 cycles, p0_ack_o one pulse 1 cycle after ack, p0_data_o = memory line, p1 outputs 0.
2. Both ports assert reads the same cycle, ARB_MODE=0 -> port 1 served first (grant_o=1), then port 0 after one IDLE cycle; p0_data_o and p1_data_o each hold their own line.
3. ARB_MODE=1, both hold requests for 4 transactions -> grant order 0,1,0,1 (pointer starts 0 so port 1 wins first only if last grant was 0; check reset order).
4. Port 1 write of 256'hA5..A5 to 0x100 -> mem_write_o=1, mem_data_o=A5 pattern through all of BUSY, p1_ack_o pulses, p1_data_o unchanged.
5. Memory never acks, TIMEOUT=8 -> after 8 BUSY cycles err_o=1, requester ack pulses, arbiter returns to IDLE and serves the next request normally.
6. rst_i low during BUSY -> all outputs 0 immediately without clock, no ack issued; after release, a new request is served from IDLE.
